// File: rtl/cpu_pkg.sv
// Shared opcode, ALU-control and sequencer state encodings for the CPU cores.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode decode; shared between the multi-cycle and pipelined cores.
module opcode_decoder
    import cpu_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int ALUCTRL_W = 3
) (
    input  logic [OPCODE_W-1:0]  opcode,
    output logic [ALUCTRL_W-1:0] alu_sel,
    output logic                 wr,
    output logic                 is_mul,
    output logic                 is_halt,
    output logic                 is_illegal
);

    // any set bit above the 4-bit opcode field makes the op illegal
    logic [OPCODE_W-1:0] hi_bits;
    assign hi_bits = opcode & ~OPCODE_W'(4'hF);

    always_comb begin
        alu_sel    = '0;
        wr         = 1'b0;
        is_mul     = 1'b0;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (hi_bits != '0) begin
            is_illegal = 1'b1;
        end else begin
            case (opcode[3:0])
                OP_NOP:  ;
                OP_ADD:  begin alu_sel = ALUCTRL_W'(ALU_ADD); wr = 1'b1; end
                OP_SUB:  begin alu_sel = ALUCTRL_W'(ALU_SUB); wr = 1'b1; end
                OP_AND:  begin alu_sel = ALUCTRL_W'(ALU_AND); wr = 1'b1; end
                OP_OR:   begin alu_sel = ALUCTRL_W'(ALU_OR);  wr = 1'b1; end
                OP_MUL:  begin alu_sel = ALUCTRL_W'(ALU_MUL); wr = 1'b1; is_mul = 1'b1; end
                OP_HALT: is_halt = 1'b1;
                default: is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle CPU sequencer: FETCH/DECODE/EXECUTE/WRITEBACK with multi-cycle MUL and sticky HALT.
// state    | meaning
// S_FETCH  | wait for instr_valid, latch opcode
// S_DECODE | decode latched opcode, pick EXEC or HALT
// S_EXEC   | drive ALUControl; MUL stays MUL_CYCLES cycles
// S_WB     | RegWrite/pc_en/illegal_op pulses
// S_HALT   | halt=1 until reset
module multicycle_control_fsm
    import cpu_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter int ALUCTRL_W  = 3,
    parameter int MUL_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 instr_valid,
    input  logic [OPCODE_W-1:0]  opcode,
    output logic                 ir_load,
    output logic                 pc_en,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 RegWrite,
    output logic                 alu_busy,
    output logic                 illegal_op,
    output logic                 halt
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

    state_t              state;
    logic [OPCODE_W-1:0] opcode_q;
    logic [CNT_W-1:0]    cnt;

    logic [ALUCTRL_W-1:0] alu_sel;
    logic                 wr, is_mul, is_halt, is_illegal;

    opcode_decoder #(
        .OPCODE_W  (OPCODE_W),
        .ALUCTRL_W (ALUCTRL_W)
    ) u_dec (
        .opcode     (opcode_q),
        .alu_sel    (alu_sel),
        .wr         (wr),
        .is_mul     (is_mul),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    // Outputs are registered alongside the next state so they line up with the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_FETCH;
            opcode_q   <= '0;
            cnt        <= '0;
            ir_load    <= 1'b0;
            pc_en      <= 1'b0;
            ALUControl <= '0;
            RegWrite   <= 1'b0;
            alu_busy   <= 1'b0;
            illegal_op <= 1'b0;
            halt       <= 1'b0;
        end else begin
            ir_load    <= 1'b0;
            pc_en      <= 1'b0;
            RegWrite   <= 1'b0;
            illegal_op <= 1'b0;
            case (state)
                S_FETCH: begin
                    ALUControl <= '0;
                    alu_busy   <= 1'b0;
                    if (instr_valid) begin
                        opcode_q <= opcode;
                        ir_load  <= 1'b1;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    cnt <= '0;
                    if (is_halt) begin
                        ALUControl <= '0;
                        halt       <= 1'b1;
                        state      <= S_HALT;
                    end else begin
                        ALUControl <= alu_sel;
                        alu_busy   <= is_mul;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_mul && cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt        <= '0;
                        alu_busy   <= 1'b0;
                        RegWrite   <= wr;
                        pc_en      <= 1'b1;
                        illegal_op <= is_illegal;
                        state      <= S_WB;
                    end
                end
                S_WB: begin
                    ALUControl <= '0;
                    state      <= S_FETCH;
                end
                S_HALT: begin
                    ALUControl <= '0;
                    alu_busy   <= 1'b0;
                    halt       <= 1'b1;
                end
                default: begin
                    cnt        <= '0;
                    ALUControl <= '0;
                    alu_busy   <= 1'b0;
                    halt       <= 1'b0;
                    state      <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench for multicycle_control_fsm against a cycle-indexed trace model.
module tb_multicycle_control_fsm;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       iv0, iv1;
    logic [3:0] op0, op1;
    logic       irl0, pce0, rw0, bsy0, ill0, hlt0;
    logic       irl1, pce1, rw1, bsy1, ill1, hlt1;
    logic [2:0] alu0, alu1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.OPCODE_W(4), .ALUCTRL_W(3), .MUL_CYCLES(4)) dut0 (
        .clk(clk), .reset(reset), .instr_valid(iv0), .opcode(op0),
        .ir_load(irl0), .pc_en(pce0), .ALUControl(alu0), .RegWrite(rw0),
        .alu_busy(bsy0), .illegal_op(ill0), .halt(hlt0)
    );

    multicycle_control_fsm #(.OPCODE_W(4), .ALUCTRL_W(3), .MUL_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .instr_valid(iv1), .opcode(op1),
        .ir_load(irl1), .pc_en(pce1), .ALUControl(alu1), .RegWrite(rw1),
        .alu_busy(bsy1), .illegal_op(ill1), .halt(hlt1)
    );

    // vector layout: {ir_load, pc_en, ALUControl[2:0], RegWrite, alu_busy, illegal_op, halt}
    function automatic logic [8:0] obs(input int which);
        if (which == 0) return {irl0, pce0, alu0, rw0, bsy0, ill0, hlt0};
        return {irl1, pce1, alu1, rw1, bsy1, ill1, hlt1};
    endfunction

    function automatic logic [2:0] alu_of(input logic [3:0] op);
        case (op)
            4'd1: return 3'b000;
            4'd2: return 3'b001;
            4'd3: return 3'b100;
            4'd4: return 3'b101;
            4'd5: return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected outputs k cycles after the accept cycle, for a non-HALT opcode.
    function automatic logic [8:0] model(input logic [3:0] op, input int k, input int mc);
        logic mul, wr, ill;
        int   e;
        mul = (op == 4'd5);
        wr  = (op >= 4'd1 && op <= 4'd5);
        ill = (op >= 4'd6 && op <= 4'd14);
        e   = mul ? mc : 1;
        if (k == 1)               return 9'b1_0_000_0_0_0_0;
        if (k >= 2 && k <= 1 + e) return {1'b0, 1'b0, alu_of(op), 1'b0, mul, 1'b0, 1'b0};
        if (k == 2 + e)           return {1'b0, 1'b1, alu_of(op), wr, 1'b0, ill, 1'b0};
        return 9'b0;
    endfunction

    task automatic chk(input string tag, input logic [8:0] o, input logic [8:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic drive(input int which, input logic v, input logic [3:0] op);
        if (which == 0) begin iv0 = v; op0 = op; end
        else            begin iv1 = v; op1 = op; end
    endtask

    // Entered at a negedge in a FETCH cycle; returns at a negedge in the following FETCH cycle.
    task automatic run(input int which, input logic [3:0] op, input int gap);
        int mc, e;
        mc = (which == 0) ? 4 : 1;
        e  = (op == 4'd5) ? mc : 1;
        for (int i = 0; i < gap; i++) begin
            chk("idle", obs(which), 9'b0);
            drive(which, 1'b0, 4'($urandom));
            @(negedge clk);
        end
        chk("fetch", obs(which), 9'b0);
        drive(which, 1'b1, op);
        @(negedge clk);
        for (int k = 1; k <= 2 + e; k++) begin
            chk($sformatf("op%0h_k%0d", op, k), obs(which), model(op, k, mc));
            if (k == 2 + e) drive(which, 1'b0, 4'($urandom));
            else            drive(which, 1'($urandom), 4'($urandom));
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 4'd0);
        drive(1, 1'b0, 4'd0);
        repeat (2) @(negedge clk);
        chk("reset0", obs(0), 9'b0);
        chk("reset1", obs(1), 9'b0);
        reset = 1'b0;
        @(negedge clk);

        // reset in the middle of a MUL
        chk("pre_mul", obs(0), 9'b0);
        drive(0, 1'b1, 4'd5);
        @(negedge clk);
        drive(0, 1'b0, 4'd0);
        repeat (2) @(negedge clk);
        chk("mul_busy", obs(0), model(4'd5, 3, 4));
        #2 reset = 1'b1;
        #1;
        chk("mid_reset", obs(0), 9'b0);
        checks++;
        assert (dut0.state === S_FETCH) else begin
            errors++;
            $error("FAIL mid_reset_state observed %0d expected %0d", dut0.state, S_FETCH);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // directed: ADD, MUL, idle 5 then accept, illegal, NOP
        run(0, 4'd1, 0);
        run(0, 4'd5, 0);
        run(0, 4'd2, 5);
        run(0, 4'd9, 1);
        run(0, 4'd0, 0);

        for (int n = 0; n < 40; n++)
            run(0, 4'($urandom_range(0, 14)), $urandom_range(0, 2));

        run(1, 4'd5, 0);
        run(1, 4'd1, 0);
        for (int n = 0; n < 12; n++)
            run(1, 4'($urandom_range(0, 14)), $urandom_range(0, 2));

        // HALT is sticky and ignores instr_valid
        chk("pre_halt", obs(0), 9'b0);
        drive(0, 1'b1, 4'd15);
        @(negedge clk);
        chk("halt_decode", obs(0), 9'b1_0_000_0_0_0_0);
        drive(0, 1'b1, 4'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk($sformatf("halted_%0d", i), obs(0), 9'b0_0_000_0_0_0_1);
        end
        reset = 1'b1;
        #1;
        chk("halt_reset", obs(0), 9'b0);
        drive(0, 1'b0, 4'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(0, 4'd4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
